bird_column_ctrl: RTL and testbench
===================================

# bird_column_ctrl

Game controller for the bird column of the Floppy Bird display: owns the bird's vertical position across an N-light column, turns raw button presses into single flap events, generates the gravity "fall" tick, and sequences the game through idle, play and crashed states. It drives the per-light on/off pattern of the column and provides the fall/flap pulses that the rest of the display logic samples. It sits between the player button and obstacle-collision logic on one side and the column LEDs on the other.

## Interface

Parameters:
- N, 8, number of lights in the column; positions 0 (ground) to N-1 (top).
- FALL_PERIOD, 50, clock cycles between gravity ticks in PLAY; must be ≥ 2.
- START_POS, 4, bird position in IDLE and after restart; 0 ≤ START_POS ≤ N-1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- button  in  1  player button level, already synchronized to clk.
- collide  in  1  level from obstacle logic; 1 = bird overlaps a pipe this cycle.
- lights  out  N  one-hot bird position; bit i on ⇔ bird at position i.
- flap  out  1  one-cycle pulse: accepted flap event in PLAY.
- fall  out  1  one-cycle pulse: gravity tick in PLAY.
- playing  out  1  1 in PLAY.
- crashed  out  1  1 in DEAD.

## Operation

- States: IDLE, PLAY, DEAD.
- Button edge: btn_q registers button; edge = button & ~btn_q.
- IDLE: pos = START_POS, gravity counter held at 0. Edge → PLAY; this start edge is not a flap.
- PLAY:
  - Gravity counter cnt counts 0..FALL_PERIOD-1 and wraps; fall = 1 in the cycle where cnt = FALL_PERIOD-1.
  - flap = edge. On flap: pos = min(pos+1, N-1) (saturates at top, no crash); cnt ← 0.
  - On fall without flap: pos > 0 → pos-1; pos = 0 → DEAD (ground hit), pos stays 0.
  - Flap and fall in the same cycle: flap wins, fall is still pulsed, pos increments, cnt ← 0.
  - collide = 1 → DEAD on that edge, pos frozen; takes priority over flap/fall position update.
- DEAD: lights hold last position, counter held, flap/fall = 0. Edge → IDLE (pos ← START_POS).
- collide is ignored outside PLAY.

## Timing

- Reset (reset = 0, async): state IDLE, pos = START_POS, cnt = 0, btn_q = 0; lights = one-hot START_POS, flap = fall = 0, playing = 0, crashed = 0. Released synchronously effective on the next clk edge.
- flap and fall are combinational from registered state and button; playing, crashed, lights are pure functions of registered state.
- Latency: button rising between edges k-1 and k → flap high in the cycle before edge k; lights show new position after edge k.
- First fall after entering PLAY (or after a flap): exactly FALL_PERIOD cycles later.
- Held button generates one flap only; a new flap needs button low for ≥ 1 sampled cycle.
- Reset mid-game: immediate return to IDLE values, no pulses.

## Structure

- Package bird_pkg: state enum (IDLE, PLAY, DEAD) and default parameter constants.
- Sub-module fall_timer: parameterized FALL_PERIOD counter with enable and synchronous clear inputs, tick output; width $clog2(FALL_PERIOD).
- Top holds FSM, edge detector, position register and one-hot decode.

## Test plan

- Reset then idle: reset low 3 cycles, release, no button for 200 cycles → lights = 8'b0001_0000, playing = 0, no fall pulses.
- Start and gravity: button edge → playing = 1; fall pulses exactly every 50 cycles; lights walk 4→3→2→1→0; fall at pos 0 → crashed = 1, lights = 8'b0000_0001.
- Flap and saturation: in PLAY from pos 4, five single-cycle presses spaced 3 cycles → pos 5,6,7,7,7; no crash; next fall exactly 50 cycles after last flap.
- Held button: button held 120 cycles in PLAY → one flap pulse only, falls continue every 50 cycles from the flap.
- Collision and simultaneity: flap coincident with fall at cnt = 49 → pos+1, fall pulsed; later collide = 1 at pos 6 → crashed = 1, lights frozen at bit 6; button edge → IDLE, pos 4.
- Async reset mid-play: assert reset between edges at pos 2 → outputs return to reset values immediately, before next edge.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared types and default sizing for the Floppy Bird column controller.
// Imported by the timer sub-module and the column controller top.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int N_DEF           = 8;
    localparam int FALL_PERIOD_DEF = 50;
    localparam int START_POS_DEF   = 4;

endpackage

// File: rtl/bird_column_ctrl_if.sv
// Player/obstacle inputs and column/pulse outputs of the bird controller.
// The controller takes the slave view; whoever drives the button takes master.
interface bird_column_ctrl_if #(
    parameter int N = 8
);
    logic         button;
    logic         collide;
    logic [N-1:0] lights;
    logic         flap;
    logic         fall;
    logic         playing;
    logic         crashed;

    modport master (
        output button,
        output collide,
        input  lights,
        input  flap,
        input  fall,
        input  playing,
        input  crashed
    );

    modport slave (
        input  button,
        input  collide,
        output lights,
        output flap,
        output fall,
        output playing,
        output crashed
    );
endinterface

// File: rtl/fall_timer.sv
// Gravity counter: runs 0..PERIOD-1 while enabled, ticks on the last count.
// A synchronous clear restarts the full period (used on flaps and in idle).
module fall_timer
    import bird_pkg::*;
#(
    parameter int PERIOD = FALL_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    assign tick = en & (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bird_column_ctrl.sv
// Bird column controller: game FSM, button edge detect, position register
// and one-hot column decode; gravity comes from the fall_timer instance.
module bird_column_ctrl
    import bird_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int FALL_PERIOD = FALL_PERIOD_DEF,
    parameter int START_POS   = START_POS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    bird_column_ctrl_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] TOP   = PW'(N - 1);
    localparam logic [PW-1:0] START = PW'(START_POS);

    state_t          state;
    logic [PW-1:0]   pos;
    logic            btn_q;
    logic            btn_edge;
    logic            in_play;
    logic            flap;
    logic            fall;
    logic            clr;
    logic [N-1:0]    lights;

    assign btn_edge = bus.button & ~btn_q;
    assign in_play  = (state == PLAY);
    assign flap     = in_play & btn_edge;
    // Idle keeps the counter parked at zero so play starts a full period.
    assign clr      = flap | (state == IDLE);

    fall_timer #(
        .PERIOD (FALL_PERIOD)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (in_play),
        .clr   (clr),
        .tick  (fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= bus.button;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pos   <= START;
        end else begin
            unique case (state)
                IDLE: begin
                    pos <= START;
                    if (btn_edge) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    // Collision freezes the bird ahead of any flap or fall.
                    if (bus.collide) begin
                        state <= DEAD;
                    end else if (flap) begin
                        if (pos != TOP) begin
                            pos <= pos + 1'b1;
                        end
                    end else if (fall) begin
                        if (pos == '0) begin
                            state <= DEAD;
                        end else begin
                            pos <= pos - 1'b1;
                        end
                    end
                end
                DEAD: begin
                    if (btn_edge) begin
                        state <= IDLE;
                        pos   <= START;
                    end
                end
                default: begin
                    state <= IDLE;
                    pos   <= START;
                end
            endcase
        end
    end

    always_comb begin
        lights      = '0;
        lights[pos] = 1'b1;
    end

    assign bus.lights  = lights;
    assign bus.flap    = flap;
    assign bus.fall    = fall;
    assign bus.playing = in_play;
    assign bus.crashed = (state == DEAD);
endmodule

// File: tb/tb_bird_column_ctrl.sv
// Scoreboard bench for bird_column_ctrl: expected column/status snapshots
// are queued with each stimulus and popped when the DUT reaches that point.
module tb_bird_column_ctrl;

    typedef struct packed {
        logic [7:0] lights;
        logic       playing;
        logic       crashed;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   fall_cnt = 0;
    int   flap_cnt = 0;
    exp_t q[$];

    bird_column_ctrl_if #(.N(8)) bus();

    bird_column_ctrl #(
        .N           (8),
        .FALL_PERIOD (50),
        .START_POS   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fall === 1'b1) fall_cnt++;
        if (bus.flap === 1'b1) flap_cnt++;
    end

    function automatic exp_t obs();
        return exp_t'({bus.lights, bus.playing, bus.crashed});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (bus.fall === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int f0;
        reset = 1'b0;
        bus.button = 1'b0;
        bus.collide = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        q.push_back(exp_t'{8'h10, 1'b0, 1'b0});
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs(), e);
        end
        total++;
        if ({bus.flap, bus.fall} !== 2'b00) begin
            bad++;
            $display("FAIL reset_pulses: got %b want 00", {bus.flap, bus.fall});
        end
        reset = 1'b1;
        f0 = fall_cnt;
        q.push_back(exp_t'{8'h10, 1'b0, 1'b0});
        repeat (200) tick();
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL idle_hold: got %h want %h", obs(), e);
        end
        total++;
        if (fall_cnt - f0 !== 0) begin
            bad++;
            $display("FAIL idle_falls: got %0d want 0", fall_cnt - f0);
        end
    endtask

    task automatic test_gravity();
        exp_t e;
        int n;
        bus.button = 1'b1;
        q.push_back(exp_t'{8'h10, 1'b1, 1'b0});
        tick();
        bus.button = 1'b0;
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL start: got %h want %h", obs(), e);
        end
        q.push_back(exp_t'{8'h08, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h04, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h02, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h01, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h01, 1'b0, 1'b1});
        for (int i = 0; i < 5; i++) begin
            wait_fall(n);
            total++;
            if (n !== 50) begin
                bad++;
                $display("FAIL fall_gap%0d: got %0d want 50", i, n);
            end
            tick();
            e = q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL gravity%0d: got %h want %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_flap();
        exp_t e;
        int n;
        int f0;
        bus.button = 1'b1;
        tick();
        bus.button = 1'b0;
        tick();
        q.push_back(exp_t'{8'h10, 1'b0, 1'b0});
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL restart_idle: got %h want %h", obs(), e);
        end
        bus.button = 1'b1;
        tick();
        bus.button = 1'b0;
        tick();
        f0 = fall_cnt;
        q.push_back(exp_t'{8'h20, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h40, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h80, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h80, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h80, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            bus.button = 1'b1;
            @(negedge clk);
            total++;
            if (bus.flap !== 1'b1) begin
                bad++;
                $display("FAIL flap_pulse%0d: got %b want 1", i, bus.flap);
            end
            @(posedge clk);
            #1;
            bus.button = 1'b0;
            e = q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL flap%0d: got %h want %h", i, obs(), e);
            end
            if (i < 4) begin
                tick();
                tick();
            end
        end
        total++;
        if (fall_cnt - f0 !== 0) begin
            bad++;
            $display("FAIL flap_nofall: got %0d want 0", fall_cnt - f0);
        end
        wait_fall(n);
        total++;
        if (n !== 50) begin
            bad++;
            $display("FAIL flap_fall_gap: got %0d want 50", n);
        end
        q.push_back(exp_t'{8'h40, 1'b1, 1'b0});
        tick();
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flap_fall: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_held();
        exp_t e;
        int n;
        int p0;
        p0 = flap_cnt;
        bus.button = 1'b1;
        @(negedge clk);
        total++;
        if (bus.flap !== 1'b1) begin
            bad++;
            $display("FAIL held_flap: got %b want 1", bus.flap);
        end
        q.push_back(exp_t'{8'h80, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h40, 1'b1, 1'b0});
        q.push_back(exp_t'{8'h20, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL held_up: got %h want %h", obs(), e);
        end
        for (int i = 0; i < 2; i++) begin
            wait_fall(n);
            total++;
            if (n !== 50) begin
                bad++;
                $display("FAIL held_gap%0d: got %0d want 50", i, n);
            end
            tick();
            e = q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL held_fall%0d: got %h want %h", i, obs(), e);
            end
        end
        repeat (19) tick();
        bus.button = 1'b0;
        total++;
        if (flap_cnt - p0 !== 1) begin
            bad++;
            $display("FAIL held_count: got %0d want 1", flap_cnt - p0);
        end
    endtask

    task automatic test_simul();
        exp_t e;
        int n;
        int f0;
        wait_fall(n);
        total++;
        if (n !== 31) begin
            bad++;
            $display("FAIL simul_gap: got %0d want 31", n);
        end
        bus.button = 1'b1;
        #1;
        total++;
        if ({bus.flap, bus.fall} !== 2'b11) begin
            bad++;
            $display("FAIL simul_pulses: got %b want 11", {bus.flap, bus.fall});
        end
        q.push_back(exp_t'{8'h40, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        bus.button = 1'b0;
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL simul_pos: got %h want %h", obs(), e);
        end
        tick();
        bus.collide = 1'b1;
        q.push_back(exp_t'{8'h40, 1'b0, 1'b1});
        q.push_back(exp_t'{8'h40, 1'b0, 1'b1});
        tick();
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL collide: got %h want %h", obs(), e);
        end
        f0 = fall_cnt;
        repeat (60) tick();
        bus.collide = 1'b0;
        e = q.pop_front();
        total++;
        if (obs() !== e || fall_cnt !== f0) begin
            bad++;
            $display("FAIL dead_hold: got %h/%0d want %h/0", obs(), fall_cnt - f0, e);
        end
        bus.button = 1'b1;
        q.push_back(exp_t'{8'h10, 1'b0, 1'b0});
        tick();
        bus.button = 1'b0;
        tick();
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL dead_to_idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int n;
        bus.button = 1'b1;
        tick();
        bus.button = 1'b0;
        wait_fall(n);
        tick();
        wait_fall(n);
        tick();
        q.push_back(exp_t'{8'h04, 1'b1, 1'b0});
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL pre_reset: got %h want %h", obs(), e);
        end
        #2;
        bus.button = 1'b1;
        reset = 1'b0;
        #1;
        q.push_back(exp_t'{8'h10, 1'b0, 1'b0});
        e = q.pop_front();
        total++;
        if (obs() !== e || {bus.flap, bus.fall} !== 2'b00) begin
            bad++;
            $display("FAIL async_reset: got %h/%b want %h/00", obs(), {bus.flap, bus.fall}, e);
        end
        bus.button = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        q.push_back(exp_t'{8'h10, 1'b0, 1'b0});
        e = q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL post_reset: got %h want %h", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_flap();
        test_held();
        test_simul();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
